fb_bunch_sequencer: RTL and testbench
=====================================

FB_BUNCH_SEQUENCER -- requirements
Module: fb_bunch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock, all logic on rising edge; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL provide these ports:
- trig  input  1  start-of-store request, one-cycle pulse.
- n_bunch  input  2  bunches per store; value 0 treated as 1.
- bunch_spacing  input  8  cycles between bunch strobes; values below 8 treated as 8.
- store_len  input  12  requested store window length in cycles.
- fb_en_in  input  1  feedback enable request.
- charge_k0, charge_k1, charge_k2  input  21 each  signed per-bunch charge coefficients.
- dsp_oflow  input  1  overflow flag from the DSP calculation datapath.
- store_strb  output  1  store window to the datapath.
- bunch_strb  output  1  one-cycle bunch strobe.
- delay_en  output  1  pass result to the next bunch.
- fb_en  output  1  feedback enable to the datapath.
- charge_out  output  21  signed coefficient for the current bunch.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle end-of-sequence pulse.
- oflow_flags  output  3  per-bunch sticky overflow flags.

Function
REQ-003 The FSM SHALL have the states IDLE, STORE, CLEAR and DONE.
REQ-004 In IDLE, trig=1 SHALL capture n_bunch, bunch_spacing, store_len, fb_en_in and charge_k0..2, and SHALL enter STORE on the next cycle.
- Captured values are the effective configuration.
- Later input changes have no effect until the next trig.
REQ-005 Cycle counter t SHALL be 0 in the first STORE cycle and increment by 1 each STORE cycle.
REQ-006 store_strb SHALL be 1 exactly while in STORE.
REQ-007 bunch_strb SHALL pulse for one cycle at t = 4 + k*S for k = 0..N-1, where S is effective spacing and N is effective bunch count.
REQ-008 charge_out SHALL equal charge_k(k) from t = 3 + k*S through the cycle before the next bunch's update.
- This gives one cycle of setup before each bunch_strb.
- charge_out holds its last value after the final bunch.
REQ-009 delay_en SHALL be 1 in STORE while the current bunch index k < N-1, and 0 otherwise.
- The last bunch never passes its result forward.
REQ-010 Effective store length SHALL be L = max(store_len, 4 + (N-1)*S + 16).
- Arithmetic is 13-bit unsigned, so it cannot overflow.
- STORE exits to CLEAR when t = L-1.
REQ-011 CLEAR SHALL last exactly 2 cycles, then go to DONE.
- This covers the datapath's DAC clear after the falling edge of store_strb.
REQ-012 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-013 fb_en SHALL equal the captured fb_en_in during STORE and CLEAR, and SHALL be 0 in IDLE and DONE.
REQ-014 busy SHALL be 1 in STORE, CLEAR and DONE.
REQ-015 A trig while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 A trig in the same cycle as DONE SHALL be ignored; only a trig in IDLE starts a sequence.

Reset
REQ-017 rst=1 SHALL force IDLE on the next edge and override all other inputs, including when asserted mid-sequence.
REQ-018 Under reset, the outputs SHALL be:
- store_strb, bunch_strb, delay_en, fb_en, busy, done = 0.
- charge_out = 0.
- oflow_flags = 0.
- Counters and captured configuration cleared.
REQ-019 An aborted sequence SHALL NOT produce done.

Configuration
REQ-020 With macro FB_SEQ_OFLOW_TRACK_EN defined, oflow_flags tracking SHALL be compiled in:
- oflow_flags[k] is set when dsp_oflow=1 during t in [4 + k*S + 3, 4 + k*S + 6].
- Flags are sticky until the next accepted trig, which clears them in the capture cycle.
REQ-021 Without FB_SEQ_OFLOW_TRACK_EN, oflow_flags SHALL be tied to 0 and no tracking logic SHALL exist; port widths SHALL be unchanged.

Verification
REQ-022 Scenario 1: n_bunch=2, spacing=20, store_len=100, trig at cycle 10.
- store_strb high cycles 11..110.
- bunch_strb at cycles 15 and 35.
- delay_en high 11..34.
- done at cycle 113.
REQ-023 Scenario 2: n_bunch=0, spacing=3, store_len=5.
- Effective N=1, S=8, L=20.
- One bunch_strb at t=4.
- store_strb lasts 20 cycles.
REQ-024 Scenario 3: n_bunch=3, spacing=10, charge_k0/k1/k2 = -5/100/7.
- charge_out = -5 at t=3..12, 100 at t=13..22, 7 from t=23.
- bunch_strb at t=4, 14, 24.
REQ-025 Scenario 4: a second trig at t=30 of an active store.
- Ignored: no restart, no timing change.
- A trig in IDLE afterwards starts a new sequence.
REQ-026 Scenario 5: rst at t=15 of a 3-bunch store.
- All outputs 0 on the next cycle, no done.
- A trig 2 cycles later runs a clean sequence.
REQ-027 Scenario 6 (macro defined): n_bunch=2, spacing=16, dsp_oflow pulsed at t=24.
- oflow_flags = 3'b010.
- The flags clear on the next accepted trig.
- With the macro undefined, oflow_flags stays 0.

Source files
------------

// File: rtl/fb_bunch_sequencer.sv
// Bunch-by-bunch feedback store sequencer: store window, bunch strobes, charge coefficients.
// Optional overflow tracking compiled in with FB_SEQ_OFLOW_TRACK_EN.
module fb_bunch_sequencer (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig,
   input  logic [1:0]         n_bunch,
   input  logic [7:0]         bunch_spacing,
   input  logic [11:0]        store_len,
   input  logic               fb_en_in,
   input  logic signed [20:0] charge_k0,
   input  logic signed [20:0] charge_k1,
   input  logic signed [20:0] charge_k2,
   input  logic               dsp_oflow,
   output logic               store_strb,
   output logic               bunch_strb,
   output logic               delay_en,
   output logic               fb_en,
   output logic signed [20:0] charge_out,
   output logic               busy,
   output logic               done,
   output logic [2:0]         oflow_flags
);

   typedef enum logic [1:0] {
      IDLE,
      STORE,
      CLEAR,
      DONE
   } state_t;

   state_t             state_q;
   logic [1:0]         n_q;
   logic [7:0]         s_q;
   logic [12:0]        len_q;
   logic [12:0]        last_q;
   logic               fb_q;
   logic signed [20:0] k0_q;
   logic signed [20:0] k1_q;
   logic signed [20:0] k2_q;
   logic [12:0]        t_q;
   logic [12:0]        bt_q;
   logic [1:0]         bc_q;
   logic               clr_q;

   logic               store_q;
   logic               bstrb_q;
   logic               dly_q;
   logic               fben_q;
   logic signed [20:0] chg_q;
   logic               busy_q;
   logic               done_q;

   logic [1:0]         n_eff;
   logic [7:0]         s_eff;
   logic [12:0]        tail;
   logic [12:0]        last_eff;
   logic [12:0]        span;
   logic [12:0]        len_eff;
   logic [12:0]        t_d;
   logic               strb_hit;
   logic               chg_hit;
   logic signed [20:0] chg_sel;

   // Effective configuration derived from the live inputs at capture time.
   always_comb begin
      n_eff = (n_bunch == 2'd0) ? 2'd1 : n_bunch;
      s_eff = (bunch_spacing < 8'd8) ? 8'd8 : bunch_spacing;
      unique case (n_eff)
         2'd2:    tail = {5'd0, s_eff};
         2'd3:    tail = {4'd0, s_eff, 1'b0};
         default: tail = 13'd0;
      endcase
      last_eff = 13'd4 + tail;
      span     = last_eff + 13'd16;
      len_eff  = ({1'b0, store_len} > span) ? {1'b0, store_len} : span;
   end

   // Strobe fires when the next t reaches bt_q; the coefficient loads one cycle earlier.
   always_comb begin
      t_d      = t_q + 13'd1;
      strb_hit = (t_d == bt_q) && (bc_q < n_q);
      chg_hit  = ((t_d + 13'd1) == bt_q) && (bc_q < n_q);
      unique case (bc_q)
         2'd0:    chg_sel = k0_q;
         2'd1:    chg_sel = k1_q;
         default: chg_sel = k2_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= 2'd0;
         s_q     <= 8'd0;
         len_q   <= 13'd0;
         last_q  <= 13'd0;
         fb_q    <= 1'b0;
         k0_q    <= '0;
         k1_q    <= '0;
         k2_q    <= '0;
         t_q     <= 13'd0;
         bt_q    <= 13'd0;
         bc_q    <= 2'd0;
         clr_q   <= 1'b0;
         store_q <= 1'b0;
         bstrb_q <= 1'b0;
         dly_q   <= 1'b0;
         fben_q  <= 1'b0;
         chg_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               bstrb_q <= 1'b0;
               done_q  <= 1'b0;
               if (trig) begin
                  state_q <= STORE;
                  n_q     <= n_eff;
                  s_q     <= s_eff;
                  len_q   <= len_eff;
                  last_q  <= last_eff;
                  fb_q    <= fb_en_in;
                  k0_q    <= charge_k0;
                  k1_q    <= charge_k1;
                  k2_q    <= charge_k2;
                  t_q     <= 13'd0;
                  bt_q    <= 13'd4;
                  bc_q    <= 2'd0;
                  store_q <= 1'b1;
                  dly_q   <= (n_eff != 2'd1);
                  fben_q  <= fb_en_in;
                  busy_q  <= 1'b1;
               end
            end
            STORE: begin
               if (t_q == len_q - 13'd1) begin
                  state_q <= CLEAR;
                  clr_q   <= 1'b0;
                  store_q <= 1'b0;
                  bstrb_q <= 1'b0;
                  dly_q   <= 1'b0;
               end else begin
                  t_q     <= t_d;
                  bstrb_q <= strb_hit;
                  if (strb_hit) begin
                     bt_q <= bt_q + {5'd0, s_q};
                     bc_q <= bc_q + 2'd1;
                  end
                  if (chg_hit) begin
                     chg_q <= chg_sel;
                  end
                  // Last bunch starts at last_q and never forwards its result.
                  dly_q <= (n_q != 2'd1) && (t_d < last_q);
               end
            end
            CLEAR: begin
               clr_q <= 1'b1;
               if (clr_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  fben_q  <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign store_strb = store_q;
   assign bunch_strb = bstrb_q;
   assign delay_en   = dly_q;
   assign fb_en      = fben_q;
   assign charge_out = chg_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef FB_SEQ_OFLOW_TRACK_EN
   logic [2:0]  flags_q;
   logic [2:0]  win;
   logic [12:0] w0;
   logic [12:0] w1;
   logic [12:0] w2;

   // Window for bunch k spans strobe time +3 .. +6.
   always_comb begin
      w0     = 13'd7;
      w1     = 13'd7 + {5'd0, s_q};
      w2     = 13'd7 + {4'd0, s_q, 1'b0};
      win[0] = (t_q >= w0) && (t_q <= w0 + 13'd3);
      win[1] = (n_q >= 2'd2) && (t_q >= w1) && (t_q <= w1 + 13'd3);
      win[2] = (n_q == 2'd3) && (t_q >= w2) && (t_q <= w2 + 13'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else if ((state_q == IDLE) && trig) begin
         flags_q <= 3'b000;
      end else if ((state_q == STORE) && dsp_oflow) begin
         flags_q <= flags_q | win;
      end
   end

   assign oflow_flags = flags_q;
`else
   logic unused_oflow;
   assign unused_oflow = dsp_oflow;
   assign oflow_flags  = 3'b000;
`endif

endmodule

// File: tb/tb_fb_bunch_sequencer.sv
// Directed self-checking bench for fb_bunch_sequencer.
// Expected timing follows the store/bunch formulas with hand-derived constants.
module tb_fb_bunch_sequencer;

   logic               clk = 1'b0;
   logic               rst;
   logic               trig;
   logic [1:0]         n_bunch;
   logic [7:0]         bunch_spacing;
   logic [11:0]        store_len;
   logic               fb_en_in;
   logic signed [20:0] charge_k0;
   logic signed [20:0] charge_k1;
   logic signed [20:0] charge_k2;
   logic               dsp_oflow;
   logic               store_strb;
   logic               bunch_strb;
   logic               delay_en;
   logic               fb_en;
   logic signed [20:0] charge_out;
   logic               busy;
   logic               done;
   logic [2:0]         oflow_flags;

   int checks = 0;
   int errors = 0;
   bit ab;

   fb_bunch_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .trig          (trig),
      .n_bunch       (n_bunch),
      .bunch_spacing (bunch_spacing),
      .store_len     (store_len),
      .fb_en_in      (fb_en_in),
      .charge_k0     (charge_k0),
      .charge_k1     (charge_k1),
      .charge_k2     (charge_k2),
      .dsp_oflow     (dsp_oflow),
      .store_strb    (store_strb),
      .bunch_strb    (bunch_strb),
      .delay_en      (delay_en),
      .fb_en         (fb_en),
      .charge_out    (charge_out),
      .busy          (busy),
      .done          (done),
      .oflow_flags   (oflow_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"},
          {26'd0, store_strb, bunch_strb, delay_en, fb_en, busy, done}, 0);
      chk({tag, "_charge"}, {11'd0, charge_out}, 0);
      chk({tag, "_oflow"}, {29'd0, oflow_flags}, 0);
   endtask

   task automatic start(input logic [1:0] n, input logic [7:0] s,
                        input logic [11:0] len, input logic fb,
                        input logic [20:0] c0, input logic [20:0] c1,
                        input logic [20:0] c2);
      n_bunch       = n;
      bunch_spacing = s;
      store_len     = len;
      fb_en_in      = fb;
      charge_k0     = c0;
      charge_k1     = c1;
      charge_k2     = c2;
      trig          = 1'b1;
      step();
      trig          = 1'b0;
      n_bunch       = 2'd3;
      bunch_spacing = 8'd9;
      store_len     = 12'd4000;
      fb_en_in      = ~fb;
      charge_k0     = 21'h0ABCD;
      charge_k1     = 21'h12345;
      charge_k2     = 21'h1F00F;
   endtask

   // Called in the first STORE cycle (t = 0).
   task automatic watch(input int L, input int b0, input int b1,
                        input int b2, input int dly_end, input logic fb,
                        input logic [20:0] c0, input logic [20:0] c1,
                        input logic [20:0] c2, input int trig_at,
                        input int rst_at, input int oflow_at,
                        input logic trig_done, output bit aborted);
      logic [20:0] ce;
      aborted = 1'b0;
      for (int t = 0; t < L; t++) begin
         chk("store_strb", {31'd0, store_strb}, 1);
         chk("busy", {31'd0, busy}, 1);
         chk("bunch_strb", {31'd0, bunch_strb},
             {31'd0, (t == b0) || (t == b1) || (t == b2)});
         chk("delay_en", {31'd0, delay_en}, {31'd0, t < dly_end});
         chk("fb_en", {31'd0, fb_en}, {31'd0, fb});
         chk("done", {31'd0, done}, 0);
         if (t >= b0 - 1) begin
            if (b2 >= 0 && t >= b2 - 1) ce = c2;
            else if (b1 >= 0 && t >= b1 - 1) ce = c1;
            else ce = c0;
            chk("charge_out", {11'd0, charge_out}, {11'd0, ce});
         end
         if (t == trig_at) trig = 1'b1;
         if (t == oflow_at) dsp_oflow = 1'b1;
         if (t == rst_at) rst = 1'b1;
         step();
         trig      = 1'b0;
         dsp_oflow = 1'b0;
         if (t == rst_at) begin
            rst = 1'b0;
            chk_zero("abort");
            aborted = 1'b1;
            for (int i = 0; i < 4; i++) begin
               chk("abort_no_done", {30'd0, done, busy}, 0);
               step();
            end
            return;
         end
      end
      for (int i = 0; i < 2; i++) begin
         chk("clr_store", {30'd0, store_strb, bunch_strb}, 0);
         chk("clr_delay", {31'd0, delay_en}, 0);
         chk("clr_busy", {31'd0, busy}, 1);
         chk("clr_fb", {31'd0, fb_en}, {31'd0, fb});
         chk("clr_done", {31'd0, done}, 0);
         step();
      end
      chk("done_pulse", {31'd0, done}, 1);
      chk("done_busy", {31'd0, busy}, 1);
      chk("done_fb", {31'd0, fb_en}, 0);
      chk("done_store", {31'd0, store_strb}, 0);
      if (trig_done) trig = 1'b1;
      step();
      trig = 1'b0;
      chk("idle_busy", {30'd0, busy, done}, 0);
      chk("idle_store", {31'd0, store_strb}, 0);
      step();
      chk("idle_hold", {30'd0, busy, store_strb}, 0);
   endtask

   initial begin
      rst           = 1'b1;
      trig          = 1'b0;
      n_bunch       = 2'd0;
      bunch_spacing = 8'd0;
      store_len     = 12'd0;
      fb_en_in      = 1'b0;
      charge_k0     = '0;
      charge_k1     = '0;
      charge_k2     = '0;
      dsp_oflow     = 1'b0;
      step();
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk_zero("reset");
      rst = 1'b0;
      step();
      chk("post_reset_idle", {30'd0, busy, store_strb}, 0);
      for (int i = 0; i < 7; i++) step();

      // Scenario 1: N=2 S=20 L=100; trig in DONE must be ignored.
      start(2'd2, 8'd20, 12'd100, 1'b1, 21'd11, -21'sd22, 21'd0);
      watch(100, 4, 24, -1, 24, 1'b1, 21'd11, -21'sd22, 21'd0,
            -1, -1, -1, 1'b1, ab);

      // Scenario 2: clamped N=1 S=8, L=20.
      start(2'd0, 8'd3, 12'd5, 1'b0, 21'd77, 21'd0, 21'd0);
      watch(20, 4, -1, -1, 0, 1'b0, 21'd77, 21'd0, 21'd0,
            -1, -1, -1, 1'b0, ab);

      // Scenario 3: three bunches, signed coefficients, L=40.
      start(2'd3, 8'd10, 12'd0, 1'b1, -21'sd5, 21'd100, 21'd7);
      watch(40, 4, 14, 24, 24, 1'b1, -21'sd5, 21'd100, 21'd7,
            -1, -1, -1, 1'b0, ab);

      // Scenario 4: retrigger at t=30 ignored, then a fresh IDLE trig.
      start(2'd2, 8'd20, 12'd100, 1'b0, 21'd1, 21'd2, 21'd3);
      watch(100, 4, 24, -1, 24, 1'b0, 21'd1, 21'd2, 21'd3,
            30, -1, -1, 1'b0, ab);
      start(2'd0, 8'd3, 12'd5, 1'b1, 21'd9, 21'd0, 21'd0);
      watch(20, 4, -1, -1, 0, 1'b1, 21'd9, 21'd0, 21'd0,
            -1, -1, -1, 1'b0, ab);

      // Scenario 5: reset at t=15 aborts, then a clean run.
      start(2'd3, 8'd10, 12'd0, 1'b1, 21'd4, 21'd5, 21'd6);
      watch(40, 4, 14, 24, 24, 1'b1, 21'd4, 21'd5, 21'd6,
            -1, 15, -1, 1'b0, ab);
      chk("aborted", {31'd0, ab}, 1);
      start(2'd3, 8'd10, 12'd0, 1'b1, -21'sd5, 21'd100, 21'd7);
      watch(40, 4, 14, 24, 24, 1'b1, -21'sd5, 21'd100, 21'd7,
            -1, -1, -1, 1'b0, ab);

      // Scenario 6: overflow at t=24 lands in bunch 1 window (23..26).
      start(2'd2, 8'd16, 12'd0, 1'b1, 21'd1, 21'd2, 21'd0);
      watch(36, 4, 20, -1, 20, 1'b1, 21'd1, 21'd2, 21'd0,
            -1, -1, 24, 1'b0, ab);
`ifdef FB_SEQ_OFLOW_TRACK_EN
      chk("oflow_sticky", {29'd0, oflow_flags}, 3'b010);
`else
      chk("oflow_tied", {29'd0, oflow_flags}, 0);
`endif
      start(2'd2, 8'd16, 12'd0, 1'b1, 21'd1, 21'd2, 21'd0);
      chk("oflow_cleared", {29'd0, oflow_flags}, 0);
      watch(36, 4, 20, -1, 20, 1'b1, 21'd1, 21'd2, 21'd0,
            -1, -1, -1, 1'b0, ab);
      chk("oflow_quiet", {29'd0, oflow_flags}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
